// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock controller: watches sync headers, slips the
// RX gearbox until alignment is found, and reports block lock.
module rx_block_lock #(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 64,
    parameter int BAD_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_signal_ok,
    input  logic [1:0] i_header,
    input  logic       i_header_valid,
    output logic       o_slip,
    output logic       o_block_lock
);

    localparam int SH_MAX = (LOCK_COUNT > WINDOW) ? LOCK_COUNT : WINDOW;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_TEST      = 2'd0,
        ST_SLIP_HOLD = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               slip_q, slip_d;
    logic               lock_q, lock_d;

    logic               hdr_ok;
    logic [SH_W-1:0]    sh_inc;
    logic [BAD_W-1:0]   bad_inc;

    // 01 and 10 are the only legal sync headers
    assign hdr_ok  = ^i_header;
    assign sh_inc  = sh_cnt_q + SH_W'(1);
    assign bad_inc = bad_cnt_q + BAD_W'(!hdr_ok);

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        if (!i_signal_ok) begin
            state_d    = ST_TEST;
            sh_cnt_d   = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
            lock_d     = 1'b0;
        end else begin
            case (state_q)
                ST_TEST: begin
                    if (i_header_valid) begin
                        if (hdr_ok) begin
                            if (sh_inc == SH_W'(LOCK_COUNT)) begin
                                lock_d    = 1'b1;
                                sh_cnt_d  = '0;
                                bad_cnt_d = '0;
                                state_d   = ST_LOCKED;
                            end else begin
                                sh_cnt_d = sh_inc;
                            end
                        end else begin
                            slip_d    = 1'b1;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                            state_d   = ST_SLIP_HOLD;
                        end
                    end
                end
                ST_SLIP_HOLD: begin
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = ST_TEST;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // bad-limit loss wins over a coincident window end
                    if (i_header_valid) begin
                        if (bad_inc == BAD_W'(BAD_LIMIT)) begin
                            lock_d    = 1'b0;
                            slip_d    = 1'b1;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                            state_d   = ST_SLIP_HOLD;
                        end else if (sh_inc == SH_W'(WINDOW)) begin
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else begin
                            sh_cnt_d  = sh_inc;
                            bad_cnt_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_TEST;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_TEST;
            sh_cnt_q   <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Bench for rx_block_lock: directed segment table, reset corner case,
// and randomized streams checked against a timestamp-based lock model.
module tb_rx_block_lock;

    localparam int LOCK_COUNT = 64;
    localparam int WINDOW     = 64;
    localparam int BAD_LIMIT  = 16;
    localparam int SLIP_WAIT  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sig_ok;
    logic [1:0] hdr;
    logic       hv;
    logic       o_slip;
    logic       o_block_lock;

    int vectors = 0;
    int miscompares = 0;

    rx_block_lock #(
        .LOCK_COUNT(LOCK_COUNT),
        .WINDOW    (WINDOW),
        .BAD_LIMIT (BAD_LIMIT),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_signal_ok   (sig_ok),
        .i_header      (hdr),
        .i_header_valid(hv),
        .o_slip        (o_slip),
        .o_block_lock  (o_block_lock)
    );

    always #5 clk = ~clk;

    // Reference model: lock run length, per-window tallies, and the
    // absolute cycle until which headers are ignored after a slip.
    int m_cyc = 0;
    int m_locked;
    int m_run;
    int m_win;
    int m_bad;
    int m_hold_end;
    int m_slip;

    int slip_seen = 0;
    int last_slip = -1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                     name, m_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked   = 0;
        m_run      = 0;
        m_win      = 0;
        m_bad      = 0;
        m_hold_end = -1;
        m_slip     = 0;
        last_slip  = -1;
    endtask

    task automatic model_slip();
        m_slip     = 1;
        m_locked   = 0;
        m_run      = 0;
        m_win      = 0;
        m_bad      = 0;
        m_hold_end = m_cyc + SLIP_WAIT;
    endtask

    task automatic model_step();
        bit good;
        m_cyc++;
        m_slip = 0;
        good = (hdr == 2'b01) || (hdr == 2'b10);
        if (!sig_ok) begin
            m_locked   = 0;
            m_run      = 0;
            m_win      = 0;
            m_bad      = 0;
            m_hold_end = -1;
        end else if (m_cyc <= m_hold_end) begin
            m_slip = 0;
        end else if (hv) begin
            if (m_locked == 0) begin
                if (good) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_locked = 1;
                        m_run    = 0;
                        m_win    = 0;
                        m_bad    = 0;
                    end
                end else begin
                    model_slip();
                end
            end else begin
                m_win++;
                if (!good) m_bad++;
                if (m_bad == BAD_LIMIT) begin
                    model_slip();
                end else if (m_win == WINDOW) begin
                    m_win = 0;
                    m_bad = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic ok, input logic v, input logic [1:0] h);
        sig_ok = ok;
        hv     = v;
        hdr    = h;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("slip", int'(o_slip), m_slip);
        chk("lock", int'(o_block_lock), m_locked);
        if (!sig_ok) last_slip = -1;
        if (o_slip) begin
            slip_seen++;
            if (last_slip >= 0)
                chk("slip_gap", int'((m_cyc - last_slip) >= SLIP_WAIT + 1), 1);
            last_slip = m_cyc;
        end
    endtask

    typedef struct {
        logic       ok;
        logic [1:0] h;
        int         step;
        int         ncyc;
        logic       exp_lock;
        int         exp_slips;
    } seg_t;

    localparam int NSEG = 17;
    seg_t segs[NSEG];

    initial begin
        int n0;
        int target;
        int start;
        int nslip;

        // Hand-derived expectations at the end of each segment.
        segs[0]  = '{1'b1, 2'b01, 2, 128, 1'b1, 0};
        segs[1]  = '{1'b1, 2'b11, 2, 30,  1'b1, 0};
        segs[2]  = '{1'b1, 2'b01, 2, 98,  1'b1, 0};
        segs[3]  = '{1'b1, 2'b11, 2, 30,  1'b1, 0};
        segs[4]  = '{1'b1, 2'b01, 2, 98,  1'b1, 0};
        segs[5]  = '{1'b1, 2'b10, 2, 96,  1'b1, 0};
        segs[6]  = '{1'b1, 2'b00, 2, 32,  1'b0, 1};
        segs[7]  = '{1'b1, 2'b11, 1, 31,  1'b0, 0};
        segs[8]  = '{1'b1, 2'b01, 1, 10,  1'b0, 0};
        segs[9]  = '{1'b1, 2'b11, 1, 1,   1'b0, 1};
        segs[10] = '{1'b1, 2'b01, 1, 32,  1'b0, 0};
        segs[11] = '{1'b1, 2'b10, 1, 63,  1'b0, 0};
        segs[12] = '{1'b1, 2'b01, 1, 1,   1'b1, 0};
        segs[13] = '{1'b0, 2'b01, 1, 1,   1'b0, 0};
        segs[14] = '{1'b0, 2'b11, 1, 5,   1'b0, 0};
        segs[15] = '{1'b1, 2'b01, 1, 64,  1'b1, 0};
        segs[16] = '{1'b1, 2'b11, 1, 16,  1'b0, 1};

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slip", int'(o_slip), 0);
        chk("rst_lock", int'(o_block_lock), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < NSEG; s++) begin
            n0 = slip_seen;
            for (int i = 0; i < segs[s].ncyc; i++) begin
                drive(segs[s].ok, (i % segs[s].step) == 0, segs[s].h);
                tick();
            end
            chk($sformatf("seg%0d_lock", s), int'(o_block_lock),
                int'(segs[s].exp_lock));
            chk($sformatf("seg%0d_slips", s), slip_seen - n0,
                segs[s].exp_slips);
        end

        // Slip pulse is high now; async reset must kill it mid-cycle.
        chk("pre_rst_slip", int'(o_slip), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_slip", int'(o_slip), 0);
        chk("async_lock", int'(o_block_lock), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_slip", int'(o_slip), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = slip_seen;
        for (int i = 0; i < LOCK_COUNT; i++) begin
            drive(1'b1, 1'b1, 2'b10);
            tick();
        end
        chk("post_rst_lock", int'(o_block_lock), 1);
        chk("post_rst_slips", slip_seen - n0, 0);

        // Misaligned random headers until the gearbox has slipped N times.
        for (int t = 0; t < 4; t++) begin
            nslip  = int'($urandom_range(1, 4));
            start  = slip_seen;
            target = slip_seen + nslip;
            for (int c = 0; c < 4000; c++) begin
                if (slip_seen < target)
                    drive(1'b1, ($urandom % 3) != 0, 2'($urandom));
                else
                    drive(1'b1, ($urandom % 3) != 0,
                          ($urandom % 2) ? 2'b01 : 2'b10);
                tick();
                if (slip_seen >= target && o_block_lock) break;
            end
            chk("rand_lock", int'(o_block_lock), 1);
            chk("rand_slips", slip_seen - start, nslip);
        end

        // Noisy locked traffic with occasional loss of signal.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 300) != 0, ($urandom % 4) != 0,
                  (($urandom % 6) == 0) ? (($urandom % 2) ? 2'b00 : 2'b11)
                                        : (($urandom % 2) ? 2'b01 : 2'b10));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", m_cyc);
        $fatal(1, "timeout");
    end

endmodule
